sort_sequencer: RTL and testbench

SORT_SEQUENCER -- requirements
Module: sort_sequencer

---
 rtl/sort_sequencer.sv | 134 +++++++++++++
 tb/tb_sort_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/sort_sequencer.sv
// sort_sequencer: loads an N-element frame, bubble-sorts it in place with a
// single compare-swap unit (one compare per cycle), then streams the sorted
// elements out smallest first over a valid/ready handshake.
module sort_sequencer #(
    parameter int N = 8,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         busy,
    output logic [7:0]   swap_count
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
    localparam logic [IW-1:0] LAST_P   = IW'(N - 2);

    typedef enum logic [1:0] {
        S_LOAD,
        S_SORT,
        S_DRAIN
    } state_t;

    state_t        state_q;
    logic [W-1:0]  mem_q [N];
    logic [IW-1:0] load_idx_q;
    logic [IW-1:0] out_idx_q;
    logic [IW-1:0] i_q;
    logic [IW-1:0] p_q;
    logic [7:0]    swp_q;
    logic          swapped_q;
    logic [7:0]    swap_count_q;

    logic [IW-1:0] i_nxt_d;
    logic [W-1:0]  a_d;
    logic [W-1:0]  b_d;
    logic          do_swap_d;
    logic          pass_end_d;

    // Compare-swap unit: looks at the current pair and decides the exchange.
    always_comb begin
        i_nxt_d    = i_q + 1'b1;
        a_d        = mem_q[i_q];
        b_d        = mem_q[i_nxt_d];
        do_swap_d  = (a_d > b_d);
        pass_end_d = (i_q == (LAST_P - p_q));
    end

    // Load / sort / drain sequencer with all frame state and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_LOAD;
            load_idx_q   <= '0;
            out_idx_q    <= '0;
            i_q          <= '0;
            p_q          <= '0;
            swp_q        <= '0;
            swapped_q    <= 1'b0;
            swap_count_q <= '0;
            for (int unsigned k = 0; k < N; k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (in_valid) begin
                        mem_q[load_idx_q] <= in_data;
                        if (load_idx_q == LAST_IDX) begin
                            state_q    <= S_SORT;
                            load_idx_q <= '0;
                            p_q        <= '0;
                            i_q        <= '0;
                            swp_q      <= '0;
                            swapped_q  <= 1'b0;
                        end else begin
                            load_idx_q <= load_idx_q + 1'b1;
                        end
                    end
                end
                S_SORT: begin
                    if (do_swap_d) begin
                        mem_q[i_q]     <= b_d;
                        mem_q[i_nxt_d] <= a_d;
                    end
                    swp_q <= swp_q + 8'(do_swap_d);
                    if (pass_end_d) begin
                        // The swap in this last compare still counts toward the pass.
                        if (!(swapped_q || do_swap_d) || (p_q == LAST_P)) begin
                            state_q      <= S_DRAIN;
                            out_idx_q    <= '0;
                            swap_count_q <= swp_q + 8'(do_swap_d);
                        end else begin
                            p_q       <= p_q + 1'b1;
                            i_q       <= '0;
                            swapped_q <= 1'b0;
                        end
                    end else begin
                        i_q <= i_nxt_d;
                        if (do_swap_d) begin
                            swapped_q <= 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        if (out_idx_q == LAST_IDX) begin
                            state_q   <= S_LOAD;
                            out_idx_q <= '0;
                        end else begin
                            out_idx_q <= out_idx_q + 1'b1;
                        end
                    end
                end
                default: state_q <= S_LOAD;
            endcase
        end
    end

    // Outputs decoded purely from registered state.
    always_comb begin
        in_ready   = (state_q == S_LOAD);
        out_valid  = (state_q == S_DRAIN);
        out_data   = (state_q == S_DRAIN) ? mem_q[out_idx_q] : '0;
        busy       = (state_q != S_LOAD) || (load_idx_q != '0);
        swap_count = swap_count_q;
    end

endmodule

// File: tb/tb_sort_sequencer.sv
// Directed bench for sort_sequencer: a table of frames with hand-computed
// sorted order, sort length and swap count, plus hand-written sequences for
// reset during SORT and in_valid held through SORT/DRAIN.
module tb_sort_sequencer;

    typedef logic [7:0] frame_t [8];

    typedef struct {
        frame_t     din;
        frame_t     exp;
        int         gaps;
        bit         stall;
        int         sort_cyc;
        logic [7:0] swaps;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       busy;
    logic [7:0] swap_count;

    int errors = 0;
    int checks = 0;

    vec_t vecs [5];

    sort_sequencer #(.N(8), .W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy),
        .swap_count (swap_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic load_frame(input frame_t d, input int first, input int gaps,
                              input bit hold, input logic [7:0] hold_val);
        for (int k = first; k < 8; k++) begin
            if (gaps > 0 && (k % 2) == 1) begin
                in_valid = 1'b0;
                repeat (gaps) @(negedge clk);
                if (k > 0) chk("busy_mid_load", busy, 1);
            end
            chk("in_ready_load", in_ready, 1);
            in_valid = 1'b1;
            in_data  = d[k];
            @(negedge clk);
        end
        in_valid = hold;
        in_data  = hold ? hold_val : 8'h00;
    endtask

    task automatic run_sort(input int exp_cyc);
        int cyc;
        cyc = 0;
        while (!out_valid && cyc < 400) begin
            chk("sort_flags", {in_ready, busy, out_data}, {1'b0, 1'b1, 8'h00});
            cyc++;
            @(negedge clk);
        end
        chk("sort_cycles", cyc, exp_cyc);
    endtask

    task automatic drain(input frame_t e, input bit stall, input logic [7:0] exp_sw);
        int  k;
        int  guard;
        bit  r;
        chk("swap_count_entry", swap_count, exp_sw);
        k = 0;
        guard = 0;
        while (k < 8 && guard < 200) begin
            r = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            out_ready = r;
            chk("out_valid", out_valid, 1);
            chk("out_data", out_data, e[k]);
            @(negedge clk);
            if (r) k++;
            guard++;
        end
        out_ready = 1'b1;
        chk("drain_done", k, 8);
        chk("post_drain", {out_valid, in_ready, busy, out_data}, {1'b0, 1'b1, 1'b0, 8'h00});
        chk("swap_count_hold", swap_count, exp_sw);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        frame_t rev, asc, f_rst, s_rst, f_hold, s_hold, f_next, s_next;

        vecs[0].din = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        vecs[0].exp = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        vecs[0].gaps = 0; vecs[0].stall = 0; vecs[0].sort_cyc = 28; vecs[0].swaps = 8'd28;

        vecs[1].din = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        vecs[1].exp = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        vecs[1].gaps = 0; vecs[1].stall = 0; vecs[1].sort_cyc = 7; vecs[1].swaps = 8'd0;

        vecs[2].din = '{8'h05, 8'h05, 8'hFF, 8'h00, 8'h05, 8'h80, 8'h00, 8'h01};
        vecs[2].exp = '{8'h00, 8'h00, 8'h01, 8'h05, 8'h05, 8'h05, 8'h80, 8'hFF};
        vecs[2].gaps = 2; vecs[2].stall = 1; vecs[2].sort_cyc = 27; vecs[2].swaps = 8'd15;

        vecs[3].din = '{8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7};
        vecs[3].exp = '{8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7};
        vecs[3].gaps = 1; vecs[3].stall = 0; vecs[3].sort_cyc = 7; vecs[3].swaps = 8'd0;

        vecs[4].din = '{8'd2, 8'd1, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        vecs[4].exp = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        vecs[4].gaps = 0; vecs[4].stall = 1; vecs[4].sort_cyc = 13; vecs[4].swaps = 8'd1;

        rev    = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        asc    = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        f_rst  = '{8'd3, 8'd1, 8'd2, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4};
        s_rst  = asc;
        f_hold = '{8'd4, 8'd3, 8'd2, 8'd1, 8'd8, 8'd7, 8'd6, 8'd5};
        s_hold = asc;
        f_next = '{8'h30, 8'h20, 8'h10, 8'h70, 8'h60, 8'h50, 8'h40, 8'h00};
        s_next = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {in_ready, out_valid, busy, out_data, swap_count},
            {1'b1, 1'b0, 1'b0, 8'h00, 8'h00});
        rst_n = 1'b1;

        for (int v = 0; v < 5; v++) begin
            load_frame(vecs[v].din, 0, vecs[v].gaps, 1'b0, 8'h00);
            run_sort(vecs[v].sort_cyc);
            drain(vecs[v].exp, vecs[v].stall, vecs[v].swaps);
        end

        // Reset pulse in the 10th SORT cycle of a reversed frame.
        load_frame(rev, 0, 0, 1'b0, 8'h00);
        repeat (9) @(negedge clk);
        chk("sort_before_reset", {in_ready, out_valid, busy}, {1'b0, 1'b0, 1'b1});
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outputs", {in_ready, out_valid, busy, out_data, swap_count},
               {1'b1, 1'b0, 1'b0, 8'h00, 8'h00});
        @(negedge clk);
        rst_n = 1'b1;
        load_frame(f_rst, 0, 0, 1'b0, 8'h00);
        run_sort(25);
        drain(s_rst, 1'b0, 8'd12);

        // in_valid held high through SORT and DRAIN with the next frame's first element.
        load_frame(f_hold, 0, 0, 1'b1, f_next[0]);
        run_sort(22);
        drain(s_hold, 1'b0, 8'd12);
        @(negedge clk);
        chk("held_first_accept", {in_ready, busy}, {1'b1, 1'b1});
        load_frame(f_next, 1, 0, 1'b0, 8'h00);
        run_sort(28);
        drain(s_next, 1'b1, 8'd16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
